// File: rtl/ntt_pipe_sched.sv
// Sequencer for a single-path-delay-feedback NTT/INTT pipeline: accepts one polynomial
// and derives per-stage enables and switch selects from one global advance counter.
module ntt_pipe_sched #(
  parameter int unsigned STAGES  = 7,
  parameter int unsigned MUL_LAT = 3,
  parameter int unsigned CNT_W   = $clog2((1 << (STAGES + 1)) + STAGES * MUL_LAT) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [STAGES-1:0] stage_en,
  output logic [STAGES-1:0] stage_sel,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NB = 1 << STAGES;
  // Sum of stage delays is mode independent, so the final count is a constant.
  localparam int unsigned T_END = 2 * NB - 2 + (STAGES - 1) * MUL_LAT;

  typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic             mode_q, mode_d;
  logic             adv;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      t_q     <= '0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    mode_d   = mode_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    adv      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StFeed;
          mode_d  = mode;
          t_d     = '0;
        end
      end
      StFeed: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        adv      = in_valid;
        if (in_valid) begin
          t_d = t_q + 1'b1;
          // During FEED t equals the number of beats already accepted.
          if (t_q == CNT_W'(NB - 1)) state_d = StDrain;
        end
      end
      StDrain: begin
        busy = 1'b1;
        adv  = 1'b1;
        t_d  = t_q + 1'b1;
        if (t_q == CNT_W'(T_END)) state_d = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  logic [CNT_W-1:0] dly [STAGES];
  logic [CNT_W-1:0] off [STAGES];

  always_comb begin : stage_ctrl
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             act;
    acc       = '0;
    cnt       = '0;
    act       = 1'b0;
    stage_en  = '0;
    stage_sel = '0;
    for (int s = 0; s < STAGES; s++) begin
      dly[s] = mode_q ? (CNT_W'(1) << s) : (CNT_W'(1) << (STAGES - 1 - s));
      off[s] = acc;
      acc    = acc + dly[s] + CNT_W'(MUL_LAT);
      cnt    = t_q - off[s];
      act    = busy && (t_q >= off[s]) && (t_q < off[s] + CNT_W'(NB) + dly[s]);
      stage_en[s]  = adv & act;
      // dly is a power of two, so masking picks bit log2(dly) of the local count.
      stage_sel[s] = act & (|(cnt & dly[s]));
    end
  end

endmodule

// File: tb/tb_ntt_pipe_sched.sv
// Bench for ntt_pipe_sched: behavioural model of stage timing checked every cycle,
// plus per-transform literal counts for the directed scenarios.
module tb_ntt_pipe_sched;

  localparam int S  = 3;
  localparam int ML = 2;
  localparam int NB = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready, busy, done;
  logic [S-1:0] stage_en, stage_sel;

  ntt_pipe_sched #(.STAGES(S), .MUL_LAT(ML)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode     (mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .stage_en (stage_en),
    .stage_sel(stage_sel),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Literal expectations for the current transform; -1 means not checked.
  int exp_feed = -1, exp_drain = -1, exp_en0 = -1, exp_en2 = -1, exp_sel2 = -1, exp_tog0 = -1;
  int exp_gap = -1;

  function automatic int dly(input int s, input bit md);
    return md ? (1 << s) : (1 << (S - 1 - s));
  endfunction

  function automatic int offs(input int s, input bit md);
    int o = 0;
    for (int k = 0; k < s; k++) o += dly(k, md) + ML;
    return o;
  endfunction

  function automatic int t_end(input bit md);
    return offs(S - 1, md) + NB + dly(S - 1, md) - 1;
  endfunction

  // Model: phase 0 idle, 1 feed, 2 drain, 3 done; m_t counts advances.
  int m_phase = 0, m_t = 0, m_beats = 0;
  bit m_mode = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase <= 0;
      m_t     <= 0;
      m_beats <= 0;
      m_mode  <= 1'b0;
    end else begin
      case (m_phase)
        0: if (start) begin
          m_phase <= 1;
          m_mode  <= mode;
          m_t     <= 0;
          m_beats <= 0;
        end
        1: if (in_valid) begin
          m_t     <= m_t + 1;
          m_beats <= m_beats + 1;
          if (m_beats + 1 == NB) m_phase <= 2;
        end
        2: begin
          m_t <= m_t + 1;
          if (m_t == t_end(m_mode)) m_phase <= 3;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial begin : compare
    bit           e_busy, e_rdy, e_done, e_adv, prev_sel0;
    logic [S-1:0] e_en, e_sel;
    int           c, d, gap, busy_run;
    int           n_feed, n_drain, n_en0, n_en2, n_sel2, n_tog0;
    prev_sel0 = 1'b0;
    gap = 0; busy_run = 0;
    n_feed = 0; n_drain = 0; n_en0 = 0; n_en2 = 0; n_sel2 = 0; n_tog0 = 0;
    forever begin
      @(negedge clk);
      e_busy = (m_phase == 1) || (m_phase == 2);
      e_rdy  = (m_phase == 1);
      e_done = (m_phase == 3);
      e_adv  = (m_phase == 2) || ((m_phase == 1) && in_valid);
      e_en   = '0;
      e_sel  = '0;
      for (int s = 0; s < S; s++) begin
        d = dly(s, m_mode);
        c = m_t - offs(s, m_mode);
        if (e_busy && c >= 0 && c < NB + d) begin
          if (e_adv) e_en = e_en | (S'(1) << s);
          if (((c / d) % 2) == 1) e_sel = e_sel | (S'(1) << s);
        end
      end
      check("in_ready", int'(in_ready), int'(e_rdy));
      check("busy", int'(busy), int'(e_busy));
      check("done", int'(done), int'(e_done));
      check("stage_en", int'(stage_en), int'(e_en));
      check("stage_sel", int'(stage_sel), int'(e_sel));

      if (rst) begin
        check("reset_outputs", int'({in_ready, busy, done, stage_en, stage_sel}), 0);
        gap = 0; busy_run = 0;
        n_feed = 0; n_drain = 0; n_en0 = 0; n_en2 = 0; n_sel2 = 0; n_tog0 = 0;
      end else begin
        if (busy) begin
          if (gap > 0 && exp_gap >= 0) check("idle_gap", gap, exp_gap);
          gap = 0;
          busy_run++;
          if (busy_run == 150) check("busy_watchdog", busy_run, 149);
          if (in_ready) n_feed++; else n_drain++;
          if (stage_sel[0] != prev_sel0) n_tog0++;
          if (stage_en[0]) n_en0++;
          if (stage_en[S-1]) n_en2++;
          if (stage_sel[S-1]) n_sel2++;
        end else begin
          gap++;
          busy_run = 0;
        end
        if (done) begin
          if (exp_feed >= 0) check("feed_cycles", n_feed, exp_feed);
          if (exp_drain >= 0) check("drain_cycles", n_drain, exp_drain);
          if (exp_en0 >= 0) check("en0_cycles", n_en0, exp_en0);
          if (exp_en2 >= 0) check("en2_cycles", n_en2, exp_en2);
          if (exp_sel2 >= 0) check("sel2_high_cycles", n_sel2, exp_sel2);
          if (exp_tog0 >= 0) check("sel0_toggles", n_tog0, exp_tog0);
          n_feed = 0; n_drain = 0; n_en0 = 0; n_en2 = 0; n_sel2 = 0; n_tog0 = 0;
        end
      end
      prev_sel0 = stage_sel[0];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_lit(input int f, input int dr, input int e0, input int e2, input int s2,
                         input int t0);
    exp_feed = f; exp_drain = dr; exp_en0 = e0; exp_en2 = e2; exp_sel2 = s2; exp_tog0 = t0;
  endtask

  // kind: 0 plain, 1 stalls on feed cycles 3 and 5, 2 start/mode noise, 3 random.
  task automatic run_xfer(input bit md, input int kind);
    bit seen;
    seen     = 1'b0;
    start    = 1'b1;
    mode     = md;
    in_valid = (kind == 0);
    tick();
    start = 1'b0;
    for (int k = 0; k < 200 && !seen; k++) begin
      case (kind)
        1: in_valid = !(k == 3 || k == 5);
        2: begin
          in_valid = 1'b1;
          start    = (k == 4 || k == 14);
          mode     = k[0];
        end
        3: begin
          in_valid = ($urandom_range(0, 9) < 7);
          start    = ($urandom_range(0, 9) == 0);
          mode     = 1'($urandom_range(0, 1));
        end
        default: in_valid = 1'b1;
      endcase
      tick();
      seen = done;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Reset in the middle of DRAIN, then a fresh NTT transform.
    start = 1'b1; mode = 1'b0;
    tick();
    start = 1'b0; in_valid = 1'b1;
    repeat (12) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0; in_valid = 1'b0;
    tick();
    set_lit(8, 11, 12, 9, 4, 2);
    run_xfer(1'b0, 0);
    tick();

    // NTT, start with in_valid in the same cycle.
    run_xfer(1'b0, 0);
    tick();

    // INTT.
    set_lit(8, 11, 9, 12, 4, 8);
    run_xfer(1'b1, 0);
    tick();

    // NTT with two feed stalls.
    set_lit(10, 11, 12, 9, 4, 2);
    run_xfer(1'b0, 1);
    tick();

    // Start pulses and mode toggling mid-transform.
    set_lit(8, 11, 12, 9, 4, 2);
    run_xfer(1'b0, 2);
    tick();

    // Back-to-back INTT with start in the cycle after done.
    set_lit(8, 11, 9, 12, 4, 8);
    run_xfer(1'b1, 0);
    exp_gap = 2;
    tick();
    run_xfer(1'b1, 0);
    exp_gap = -1;
    tick();

    // Randomised transforms with idle gaps.
    set_lit(-1, -1, -1, -1, -1, -1);
    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 3)) begin
        in_valid = 1'($urandom_range(0, 1));
        tick();
      end
      run_xfer(1'($urandom_range(0, 1)), 3);
    end

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
